wb_stage_pipelined: RTL and testbench
=====================================

Name: wb_stage_pipelined

Overview:
- Parametrised write-back stage with an integrated MEM/WB pipeline register.
- Each cycle it captures one instruction's results from the memory stage and selects among four write-back sources.
- Load data is sign- or zero-extended by byte or halfword before use.
- Drives the register-file write port. Also provides a one-cycle-delayed copy of the last committed write for decode-stage bypassing.

Parameters:
- DATA_W, 32, datapath width; multiple of 16, at least 16.
- REG_ADDR_W, 5, register-file address width.
- ZERO_REG_HARDWIRED, 1, when 1, writes to register 0 are suppressed.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  hold MEM/WB contents.
- Flush  input  1  load a bubble on this edge.
- InValid  input  1  incoming instruction valid.
- InRegWrite  input  1  instruction writes a register.
- InWriteReg  input  REG_ADDR_W  destination register.
- InWbSel  input  2  source: 0 = ALUResult, 1 = load data, 2 = LinkAddr, 3 = UpperImm.
- InALUResult  input  DATA_W  ALU output.
- InR_Data  input  DATA_W  raw memory read word.
- InLinkAddr  input  DATA_W  return address (PC+8).
- InUpperImm  input  DATA_W  immediate already shifted to the upper half.
- InLdMode  input  3  0 = word, 1 = byte signed, 2 = byte unsigned, 3 = half signed, 4 = half unsigned; 5 to 7 treated as word.
- InByteOff  input  log2(DATA_W/8)  byte offset of the load address.
- RegWrite_out  output  1  register-file write enable.
- WriteReg_out  output  REG_ADDR_W  register-file write address.
- regWriteData_output  output  DATA_W  register-file write data.
- BypValid  output  1  previous-cycle committed write valid.
- BypReg  output  REG_ADDR_W  previous committed destination.
- BypData  output  DATA_W  previous committed data.

Behaviour:
- Pipeline register:
  - The MEM/WB register captures all In* signals on the rising Clock edge.
  - Priority is Reset > Flush > Stall > load.
  - Flush clears the valid and RegWrite bits. Data fields may keep stale values.
  - Stall holds every field.
- Latency: outputs reflect inputs captured one edge earlier. The output path from the register to the outputs is combinational only.
- Load extension, applied to the registered R_Data:
  - Byte lane = R_Data[8*ByteOff +: 8].
  - Half lane = R_Data[16*(ByteOff>>1) +: 16]; ByteOff bit 0 is ignored for half loads.
  - Signed modes replicate the lane MSB up to DATA_W. Unsigned modes zero-fill.
- Source mux selects the regWriteData_output value by registered WbSel. LdMode affects source 1 only.
- RegWrite_out = valid & RegWrite & !(ZERO_REG_HARDWIRED & WriteReg == 0).
- When RegWrite_out = 0:
  - WriteReg_out and regWriteData_output still show the registered values.
  - The consumer must ignore them.
- Bypass register:
  - On each edge where Stall is low, Byp* load the current RegWrite_out, WriteReg_out and regWriteData_output.
  - When Stall is high, BypValid is cleared to 0 so a held instruction is not double-reported.
- Simultaneous events:
  - Flush with Stall: Flush wins.
  - Reset with anything: Reset wins.
  - Reset mid-stall releases the hold.
- Reset values: all outputs 0 and all internal fields 0. Reset takes effect on the first edge it is sampled high.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- With the macro defined:
  - Adds output RetireCount (32 bits).
  - The counter increments on each edge where the registered valid is 1 and Stall is 0, counting any valid retiring instruction whether or not it writes.
  - It wraps from 0xFFFFFFFF to 0 and is cleared by Reset.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset high 2 cycles, then InValid=1, InRegWrite=1, InWriteReg=8, WbSel=0, ALUResult=0x00001234 -> after one edge: RegWrite_out=1, WriteReg_out=8, regWriteData_output=0x00001234. During reset all outputs are 0.
- Load byte: R_Data=0x80FF7F01, WbSel=1.
  - LdMode=1, ByteOff=2 -> 0xFFFFFFFF.
  - LdMode=2, ByteOff=3 -> 0x00000080.
  - LdMode=3, ByteOff=2 -> 0xFFFF80FF.
  - LdMode=4, ByteOff=0 -> 0x00007F01.
- Zero-register write: InWriteReg=0, InRegWrite=1, ALUResult=5 -> RegWrite_out=0. With ZERO_REG_HARDWIRED=0 the same stimulus gives RegWrite_out=1.
- Stall and Flush:
  - Stall=1 for 3 cycles while inputs change -> outputs hold the prior instruction; BypValid=0 after the first stalled edge.
  - Stall=1 with Flush=1 -> RegWrite_out=0 on the next edge.
- Bypass: write r9=0xA5A5A5A5, then write r10=0x1 -> on the cycle r10 appears, BypValid=1, BypReg=9, BypData=0xA5A5A5A5.
- With WB_RETIRE_COUNT_EN: 5 valid instructions with one stall cycle and one flush bubble among them -> RetireCount=5.
- With WB_RETIRE_COUNT_EN: force the counter to 0xFFFFFFFF via 2^32-1 retires or a bench backdoor; one further retire -> RetireCount=0.

Source files
------------

// File: rtl/wb_stage_pipelined.sv
// Write-back stage: MEM/WB register, load extension, source select and a one-cycle bypass copy.
// Optional WB_RETIRE_COUNT_EN adds a 32-bit RetireCount output counting retired valid instructions.
module wb_stage_pipelined #(
    parameter int DATA_W             = 32,
    parameter int REG_ADDR_W         = 5,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Stall,
    input  logic                          Flush,
    input  logic                          InValid,
    input  logic                          InRegWrite,
    input  logic [REG_ADDR_W-1:0]         InWriteReg,
    input  logic [1:0]                    InWbSel,
    input  logic [DATA_W-1:0]             InALUResult,
    input  logic [DATA_W-1:0]             InR_Data,
    input  logic [DATA_W-1:0]             InLinkAddr,
    input  logic [DATA_W-1:0]             InUpperImm,
    input  logic [2:0]                    InLdMode,
    input  logic [$clog2(DATA_W/8)-1:0]   InByteOff,
    output logic                          RegWrite_out,
    output logic [REG_ADDR_W-1:0]         WriteReg_out,
    output logic [DATA_W-1:0]             regWriteData_output,
    output logic                          BypValid,
    output logic [REG_ADDR_W-1:0]         BypReg,
    output logic [DATA_W-1:0]             BypData
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [31:0]                   RetireCount
`endif
);

    localparam int OFF_W = $clog2(DATA_W/8);

    // Selects the addressed byte/half lane and extends it; unknown modes fall back to the full word.
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [DATA_W-1:0] word,
        input logic [2:0]        mode,
        input logic [OFF_W-1:0]  off
    );
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        logic [OFF_W-1:0]   hoff;
        hoff   = off >> 1;
        lane_b = word[8*off +: 8];
        lane_h = word[16*hoff +: 16];
        case (mode)
            3'd1:    load_extend = DATA_W'(lane_b);
            3'd2:    load_extend = DATA_W'($unsigned(lane_b));
            3'd3:    load_extend = DATA_W'(lane_h);
            3'd4:    load_extend = DATA_W'($unsigned(lane_h));
            default: load_extend = word;
        endcase
    endfunction

    logic                    vld_p1;
    logic                    regwrite_p1;
    logic [REG_ADDR_W-1:0]   wreg_p1;
    logic [1:0]              wbsel_p1;
    logic [DATA_W-1:0]       alu_p1;
    logic [DATA_W-1:0]       rdata_p1;
    logic [DATA_W-1:0]       link_p1;
    logic [DATA_W-1:0]       uimm_p1;
    logic [2:0]              ldmode_p1;
    logic [OFF_W-1:0]        byteoff_p1;

    logic                    vld_p2;
    logic [REG_ADDR_W-1:0]   breg_p2;
    logic [DATA_W-1:0]       bdata_p2;

    logic                    zero_reg_hit;
    logic [DATA_W-1:0]       wdata;

    // ---- MEM -> WB boundary (p0 inputs captured into p1) ----
    always_ff @(posedge Clock) begin
        if (Reset) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            wreg_p1     <= '0;
            wbsel_p1    <= '0;
            alu_p1      <= '0;
            rdata_p1    <= '0;
            link_p1     <= '0;
            uimm_p1     <= '0;
            ldmode_p1   <= '0;
            byteoff_p1  <= '0;
        end else if (Flush) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
        end else if (!Stall) begin
            vld_p1      <= InValid;
            regwrite_p1 <= InRegWrite;
            wreg_p1     <= InWriteReg;
            wbsel_p1    <= InWbSel;
            alu_p1      <= InALUResult;
            rdata_p1    <= InR_Data;
            link_p1     <= InLinkAddr;
            uimm_p1     <= InUpperImm;
            ldmode_p1   <= InLdMode;
            byteoff_p1  <= InByteOff;
        end
    end

    always_comb begin
        wdata = alu_p1;
        case (wbsel_p1)
            2'd1:    wdata = load_extend(rdata_p1, ldmode_p1, byteoff_p1);
            2'd2:    wdata = link_p1;
            2'd3:    wdata = uimm_p1;
            default: wdata = alu_p1;
        endcase
    end

    assign zero_reg_hit        = (ZERO_REG_HARDWIRED != 0) && (wreg_p1 == '0);
    assign RegWrite_out        = vld_p1 & regwrite_p1 & ~zero_reg_hit;
    assign WriteReg_out        = wreg_p1;
    assign regWriteData_output = wdata;

    // ---- WB -> bypass boundary (p1 committed write copied into p2) ----
    always_ff @(posedge Clock) begin
        if (Reset) begin
            vld_p2   <= 1'b0;
            breg_p2  <= '0;
            bdata_p2 <= '0;
        end else if (Stall) begin
            // A held instruction must not be reported to decode a second time.
            vld_p2   <= 1'b0;
        end else begin
            vld_p2   <= RegWrite_out;
            breg_p2  <= wreg_p1;
            bdata_p2 <= wdata;
        end
    end

    assign BypValid = vld_p2;
    assign BypReg   = breg_p2;
    assign BypData  = bdata_p2;

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retire_cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            retire_cnt <= '0;
        end else if (vld_p1 && !Stall) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

    assign RetireCount = retire_cnt;
`endif

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Directed bench for wb_stage_pipelined; retire-counter scenarios run when WB_RETIRE_COUNT_EN is defined.
module tb_wb_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, in_rw;
    logic [4:0]  in_wreg;
    logic [1:0]  in_wbsel;
    logic [31:0] in_alu, in_rdata, in_link, in_uimm;
    logic [2:0]  in_ldmode;
    logic [1:0]  in_boff;

    logic        rw, bvld, rw_nz, bvld_nz;
    logic [4:0]  wreg, breg, wreg_nz, breg_nz;
    logic [31:0] wdata, bdata, wdata_nz, bdata_nz;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] rcnt, rcnt_nz;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage_pipelined #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_HARDWIRED(1)) u_dut (
        .Clock(clk), .Reset(rst), .Stall(stall), .Flush(flush),
        .InValid(in_valid), .InRegWrite(in_rw), .InWriteReg(in_wreg), .InWbSel(in_wbsel),
        .InALUResult(in_alu), .InR_Data(in_rdata), .InLinkAddr(in_link), .InUpperImm(in_uimm),
        .InLdMode(in_ldmode), .InByteOff(in_boff),
        .RegWrite_out(rw), .WriteReg_out(wreg), .regWriteData_output(wdata),
        .BypValid(bvld), .BypReg(breg), .BypData(bdata)
`ifdef WB_RETIRE_COUNT_EN
        , .RetireCount(rcnt)
`endif
    );

    wb_stage_pipelined #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_HARDWIRED(0)) u_dut_nz (
        .Clock(clk), .Reset(rst), .Stall(stall), .Flush(flush),
        .InValid(in_valid), .InRegWrite(in_rw), .InWriteReg(in_wreg), .InWbSel(in_wbsel),
        .InALUResult(in_alu), .InR_Data(in_rdata), .InLinkAddr(in_link), .InUpperImm(in_uimm),
        .InLdMode(in_ldmode), .InByteOff(in_boff),
        .RegWrite_out(rw_nz), .WriteReg_out(wreg_nz), .regWriteData_output(wdata_nz),
        .BypValid(bvld_nz), .BypReg(breg_nz), .BypData(bdata_nz)
`ifdef WB_RETIRE_COUNT_EN
        , .RetireCount(rcnt_nz)
`endif
    );

    task tick();
        @(posedge clk);
        #1;
    endtask

    task drive_alu(input logic v, input logic w, input logic [4:0] r, input logic [31:0] val);
        in_valid = v; in_rw = w; in_wreg = r; in_wbsel = 2'd0; in_alu = val;
    endtask

    task test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        in_rdata = 32'h0; in_link = 32'h0; in_uimm = 32'h0; in_ldmode = 3'd0; in_boff = 2'd0;
        drive_alu(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF);
        tick(); tick();
        checks++; if (rw !== 1'b0) begin failures++; $display("FAIL reset_rw got=%0h exp=0", rw); end
        checks++; if (wreg !== 5'd0) begin failures++; $display("FAIL reset_wreg got=%0h exp=0", wreg); end
        checks++; if (wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
        checks++; if (bvld !== 1'b0) begin failures++; $display("FAIL reset_bvld got=%0h exp=0", bvld); end
        checks++; if (breg !== 5'd0) begin failures++; $display("FAIL reset_breg got=%0h exp=0", breg); end
        checks++; if (bdata !== 32'h0) begin failures++; $display("FAIL reset_bdata got=%h exp=0", bdata); end
        rst = 1'b0;
        drive_alu(1'b1, 1'b1, 5'd8, 32'h0000_1234);
        tick();
        checks++; if (rw !== 1'b1) begin failures++; $display("FAIL first_rw got=%0h exp=1", rw); end
        checks++; if (wreg !== 5'd8) begin failures++; $display("FAIL first_wreg got=%0d exp=8", wreg); end
        checks++; if (wdata !== 32'h0000_1234) begin failures++; $display("FAIL first_wdata got=%h exp=00001234", wdata); end
    endtask

    task automatic test_load();
        logic [2:0]  lm  [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd6, 3'd3, 3'd1, 3'd2, 3'd3};
        logic [1:0]  off [10] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
        logic [31:0] exp [10] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                                  32'h80FF_7F01, 32'h80FF_7F01, 32'hFFFF_80FF, 32'h0000_007F,
                                  32'h0000_00FF, 32'h0000_7F01};
        in_valid = 1'b1; in_rw = 1'b1; in_wreg = 5'd12; in_wbsel = 2'd1;
        in_rdata = 32'h80FF_7F01; in_alu = 32'h1111_1111;
        for (int i = 0; i < 10; i++) begin
            in_ldmode = lm[i]; in_boff = off[i];
            tick();
            checks++;
            if (wdata !== exp[i]) begin
                failures++;
                $display("FAIL load_mode%0d_off%0d got=%h exp=%h", lm[i], off[i], wdata, exp[i]);
            end
        end
        in_ldmode = 3'd1; in_wbsel = 2'd2; in_link = 32'h0040_0008;
        tick();
        checks++; if (wdata !== 32'h0040_0008) begin failures++; $display("FAIL sel_link got=%h exp=00400008", wdata); end
        in_wbsel = 2'd3; in_uimm = 32'h1234_0000;
        tick();
        checks++; if (wdata !== 32'h1234_0000) begin failures++; $display("FAIL sel_uimm got=%h exp=12340000", wdata); end
        in_ldmode = 3'd0; in_boff = 2'd0;
    endtask

    task test_zero_reg();
        drive_alu(1'b1, 1'b1, 5'd0, 32'd5);
        tick();
        checks++; if (rw !== 1'b0) begin failures++; $display("FAIL zero_reg_hw got=%0h exp=0", rw); end
        checks++; if (rw_nz !== 1'b1) begin failures++; $display("FAIL zero_reg_nohw got=%0h exp=1", rw_nz); end
        checks++; if (wdata !== 32'd5) begin failures++; $display("FAIL zero_reg_data got=%h exp=00000005", wdata); end
        drive_alu(1'b0, 1'b1, 5'd6, 32'd6);
        tick();
        checks++; if (rw !== 1'b0) begin failures++; $display("FAIL invalid_rw got=%0h exp=0", rw); end
    endtask

    task test_stall_flush();
        drive_alu(1'b1, 1'b1, 5'd3, 32'h33);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_alu(1'b1, 1'b1, 5'd4 + 5'(i), 32'h44 + 32'(i));
            tick();
            checks++; if (rw !== 1'b1 || wreg !== 5'd3 || wdata !== 32'h33) begin
                failures++; $display("FAIL stall_hold%0d got=%0h/%0d/%h exp=1/3/00000033", i, rw, wreg, wdata); end
            checks++; if (bvld !== 1'b0) begin failures++; $display("FAIL stall_bvld%0d got=%0h exp=0", i, bvld); end
        end
        stall = 1'b0;
        drive_alu(1'b1, 1'b1, 5'd4, 32'h44);
        tick();
        checks++; if (wreg !== 5'd4 || wdata !== 32'h44) begin
            failures++; $display("FAIL stall_release got=%0d/%h exp=4/00000044", wreg, wdata); end
        checks++; if (bvld !== 1'b1 || breg !== 5'd3 || bdata !== 32'h33) begin
            failures++; $display("FAIL stall_release_byp got=%0h/%0d/%h exp=1/3/00000033", bvld, breg, bdata); end
        stall = 1'b1; flush = 1'b1;
        tick();
        checks++; if (rw !== 1'b0) begin failures++; $display("FAIL stall_flush_rw got=%0h exp=0", rw); end
        stall = 1'b0; flush = 1'b0;
        drive_alu(1'b1, 1'b1, 5'd2, 32'h22);
        tick();
        stall = 1'b1; rst = 1'b1;
        tick();
        checks++; if (rw !== 1'b0 || wreg !== 5'd0 || wdata !== 32'h0 || bvld !== 1'b0 || bdata !== 32'h0) begin
            failures++; $display("FAIL reset_in_stall got=%0h/%0d/%h/%0h/%h exp=0/0/0/0/0", rw, wreg, wdata, bvld, bdata); end
        stall = 1'b0; rst = 1'b0;
        drive_alu(1'b1, 1'b1, 5'd5, 32'h55);
        tick();
        checks++; if (rw !== 1'b1 || wreg !== 5'd5 || wdata !== 32'h55) begin
            failures++; $display("FAIL after_reset_load got=%0h/%0d/%h exp=1/5/00000055", rw, wreg, wdata); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (rw !== 1'b0) begin failures++; $display("FAIL flush_rw got=%0h exp=0", rw); end
        checks++; if (bvld !== 1'b1 || breg !== 5'd5) begin
            failures++; $display("FAIL flush_byp got=%0h/%0d exp=1/5", bvld, breg); end
    endtask

    task test_bypass();
        drive_alu(1'b1, 1'b1, 5'd9, 32'hA5A5_A5A5);
        tick();
        drive_alu(1'b1, 1'b1, 5'd10, 32'h1);
        tick();
        checks++; if (rw !== 1'b1 || wreg !== 5'd10 || wdata !== 32'h1) begin
            failures++; $display("FAIL byp_cur got=%0h/%0d/%h exp=1/10/00000001", rw, wreg, wdata); end
        checks++; if (bvld !== 1'b1) begin failures++; $display("FAIL byp_valid got=%0h exp=1", bvld); end
        checks++; if (breg !== 5'd9) begin failures++; $display("FAIL byp_reg got=%0d exp=9", breg); end
        checks++; if (bdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL byp_data got=%h exp=a5a5a5a5", bdata); end
        drive_alu(1'b1, 1'b1, 5'd0, 32'h7);
        tick();
        checks++; if (bvld !== 1'b1 || breg !== 5'd10) begin
            failures++; $display("FAIL byp_second got=%0h/%0d exp=1/10", bvld, breg); end
        drive_alu(1'b0, 1'b0, 5'd11, 32'h8);
        tick();
        checks++; if (bvld !== 1'b0) begin failures++; $display("FAIL byp_zero_reg got=%0h exp=0", bvld); end
    endtask

`ifdef WB_RETIRE_COUNT_EN
    task test_retire_count();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_alu(1'b0, 1'b0, 5'd1, 32'h0);
        tick();
        checks++; if (rcnt !== 32'd0) begin failures++; $display("FAIL cnt_reset got=%0d exp=0", rcnt); end
        rst = 1'b0;
        drive_alu(1'b1, 1'b1, 5'd1, 32'h1); tick();
        drive_alu(1'b1, 1'b0, 5'd2, 32'h2); tick();
        stall = 1'b1; drive_alu(1'b1, 1'b1, 5'd3, 32'h3); tick();
        stall = 1'b0; tick();
        flush = 1'b1; drive_alu(1'b1, 1'b1, 5'd31, 32'h9); tick();
        flush = 1'b0;
        drive_alu(1'b1, 1'b1, 5'd4, 32'h4); tick();
        drive_alu(1'b1, 1'b1, 5'd5, 32'h5); tick();
        drive_alu(1'b0, 1'b0, 5'd0, 32'h0); tick();
        tick();
        checks++; if (rcnt !== 32'd5) begin failures++; $display("FAIL cnt_five got=%0d exp=5", rcnt); end
        drive_alu(1'b1, 1'b0, 5'd6, 32'h6);
        tick();
        force u_dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release u_dut.retire_cnt;
        tick();
        checks++; if (rcnt !== 32'd0) begin failures++; $display("FAIL cnt_wrap got=%h exp=00000000", rcnt); end
        drive_alu(1'b0, 1'b0, 5'd0, 32'h0);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_zero_reg();
        test_stall_flush();
        test_bypass();
`ifdef WB_RETIRE_COUNT_EN
        test_retire_count();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
